// File: rtl/ltc2387_sample_averager.sv
// Block averager for LTC2387 samples: sums 2^LOG2_AVG samples and emits the mean with a hold/backpressure output.
// Optional round-half-up is enabled by defining LTC2387_AVG_ROUND_EN (default: truncate toward -inf).
module ltc2387_sample_averager #(
    parameter int ADC_WIDTH = 18,
    parameter int LOG2_AVG  = 4
) (
    input  logic                        sys_clk_int,
    input  logic                        reset_n_int,
    input  logic                        enable,
    input  logic signed [ADC_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic signed [ADC_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    input  logic                        clr_ovf,
    output logic                        busy
);

    localparam int ACC_W = ADC_WIDTH + LOG2_AVG;

    // One guard bit above the accumulator keeps the rounding bias from ever wrapping.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(LOG2_AVG + 2){1'b0}}, {(ADC_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
`ifdef LTC2387_AVG_ROUND_EN
    localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(1) << (LOG2_AVG - 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                      state;
    logic signed [ACC_W-1:0]     acc;
    logic [LOG2_AVG-1:0]         sample_cnt;
    logic signed [ACC_W-1:0]     sum_next;
    logic signed [ADC_WIDTH-1:0] avg_result;
    logic                        accept;
    logic                        block_done;

    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W:0] ext;
        ext = {sum[ACC_W-1], sum};
`ifdef LTC2387_AVG_ROUND_EN
        ext = ext + RND_BIAS;
`endif
        return ext >>> LOG2_AVG;
    endfunction

    function automatic logic signed [ADC_WIDTH-1:0] sat_sample(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[ADC_WIDTH-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[ADC_WIDTH-1:0];
        else
            return v[ADC_WIDTH-1:0];
    endfunction

    assign accept     = (state == ACCUM) && enable && in_valid;
    assign block_done = accept && (sample_cnt == '1);
    assign sum_next   = acc + {{LOG2_AVG{in_data[ADC_WIDTH-1]}}, in_data};
    assign avg_result = sat_sample(round_shift(sum_next));
    assign busy       = (sample_cnt != '0);

    always_ff @(posedge sys_clk_int or negedge reset_n_int) begin
        if (!reset_n_int) begin
            state      <= IDLE;
            acc        <= '0;
            sample_cnt <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc        <= '0;
                    sample_cnt <= '0;
                    if (enable)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (!enable) begin
                        state      <= IDLE;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end else if (in_valid) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        acc        <= block_done ? '0 : sum_next;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output holding register: a new result loads only if the slot is free or draining now.
            if (block_done && (!out_valid || out_ready)) begin
                out_data  <= avg_result;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (block_done && out_valid && !out_ready)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ltc2387_sample_averager.sv
// Directed bench for ltc2387_sample_averager with LOG2_AVG=2; results are scoreboarded on each output handshake.
module tb_ltc2387_sample_averager;

    localparam int W = 18;
    localparam int L = 2;

    logic                sys_clk_int = 1'b0;
    logic                reset_n_int;
    logic                enable;
    logic signed [W-1:0] in_data;
    logic                in_valid;
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                overflow;
    logic                clr_ovf;
    logic                busy;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

`ifdef LTC2387_AVG_ROUND_EN
    localparam int EXP_111_0 = 1;
`else
    localparam int EXP_111_0 = 0;
`endif

    always #5 sys_clk_int = ~sys_clk_int;

    ltc2387_sample_averager #(
        .ADC_WIDTH(W),
        .LOG2_AVG (L)
    ) dut (
        .sys_clk_int(sys_clk_int),
        .reset_n_int(reset_n_int),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .busy       (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Handshake observed before the edge on which it takes effect.
    task automatic monitor();
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("spurious_output_queue_depth", exp_q.size(), 1);
            else
                chk("avg_out", int'($signed(out_data)), exp_q.pop_front());
        end
    endtask

    task automatic tick();
        monitor();
        @(posedge sys_clk_int);
        @(negedge sys_clk_int);
    endtask

    task automatic send(input int v);
        in_data  = v[W-1:0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int v, input bit expect_out);
        for (int i = 0; i < (1 << L) - 1; i++) send(v);
        if (expect_out) exp_q.push_back(v);
        send(v);
    endtask

    initial begin
        reset_n_int = 1'b0;
        enable      = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clr_ovf     = 1'b0;
        #3;
        chk("rst_out_data", int'($signed(out_data)), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge sys_clk_int);
        @(negedge sys_clk_int);
        reset_n_int = 1'b1;
        enable      = 1'b1;
        tick();

        // Basic average with out_valid lasting exactly one cycle
        out_ready = 1'b1;
        send(10);
        send(20);
        chk("busy_partial", int'(busy), 1);
        send(30);
        exp_q.push_back(25);
        send(40);
        chk("valid_after_4th", int'(out_valid), 1);
        chk("busy_after_block", int'(busy), 0);
        tick();
        chk("valid_one_cycle", int'(out_valid), 0);

        // Rounding-dependent result
        send(1);
        send(1);
        send(1);
        exp_q.push_back(EXP_111_0);
        send(0);
        tick();

        // Simultaneous transfer and load
        out_ready = 1'b0;
        send_block(12, 1'b1);
        for (int i = 0; i < 3; i++) send(20);
        chk("held_before_swap", int'($signed(out_data)), 12);
        out_ready = 1'b1;
        exp_q.push_back(20);
        send(20);
        chk("valid_stays_on_swap", int'(out_valid), 1);
        tick();
        chk("no_ovf_on_swap", int'(overflow), 0);

        // Backpressure drop and sticky overflow
        out_ready = 1'b0;
        send_block(5, 1'b1);
        send_block(5, 1'b0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_out_data", int'($signed(out_data)), 5);
        chk("bp_overflow", int'(overflow), 1);
        for (int i = 0; i < 3; i++) send(5);
        clr_ovf = 1'b1;
        send(5);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", int'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        out_ready = 1'b1;
        tick();
        chk("drained_valid", int'(out_valid), 0);

        // Enable drop discards the partial block
        send(100);
        send(100);
        chk("busy_before_drop", int'(busy), 1);
        enable = 1'b0;
        tick();
        chk("busy_after_drop", int'(busy), 0);
        chk("no_out_after_drop", int'(out_valid), 0);
        tick();
        enable = 1'b1;
        tick();
        send_block(8, 1'b1);
        tick();

        // Full-scale inputs must not wrap
        send_block(131071, 1'b1);
        send_block(-131072, 1'b1);
        tick();
        tick();

        // Asynchronous reset mid-block with a held result
        out_ready = 1'b0;
        send_block(9, 1'b0);
        for (int i = 0; i < 3; i++) send(50);
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        reset_n_int = 1'b0;
        #1;
        chk("async_rst_out_data", int'($signed(out_data)), 0);
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_overflow", int'(overflow), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge sys_clk_int);
        reset_n_int = 1'b1;
        out_ready   = 1'b1;
        tick();
        send_block(7, 1'b1);
        tick();
        chk("final_valid", int'(out_valid), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
